// File: rtl/nn_pkg.sv
// Shared definitions for the neuron MAC datapath.
//   - default geometry and fixed-point constants
//   - FSM state encoding used by neuron_mac_seq
//   - acc_width(): accumulator width that cannot overflow for a given
//     word width and tap count
package nn_pkg;

    localparam int N_TAPS_DEF = 28;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;
    localparam int FRAC_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } nn_state_t;

    // Each product is 2*data_w bits; summing n_taps of them needs
    // ceil(log2(n_taps)) extra bits of headroom.
    function automatic int acc_width(input int data_w, input int n_taps);
        return 2 * data_w + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/sat_relu.sv
// Saturate a wide signed value to DATA_W bits, optionally followed by ReLU.
//   din  in  IN_W   : signed input, already scaled to the output's LSB weight
//   dout out DATA_W : saturated (and, with RELU_EN=1, non-negative) result
// Purely combinational. IN_W must be larger than DATA_W.
module sat_relu #(
    parameter int IN_W    = 38,
    parameter int DATA_W  = 16,
    parameter int RELU_EN = 1
) (
    input  logic [IN_W-1:0]   din,
    output logic [DATA_W-1:0] dout
);

    logic                pos_ovf;
    logic                neg_ovf;
    logic [DATA_W-1:0]   sat_val;

    // The value fits when every bit from DATA_W-1 upward matches the sign.
    assign pos_ovf = ~din[IN_W-1] &  (|din[IN_W-2:DATA_W-1]);
    assign neg_ovf =  din[IN_W-1] & ~(&din[IN_W-2:DATA_W-1]);

    always_comb begin
        sat_val = din[DATA_W-1:0];
        if (pos_ovf) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (neg_ovf) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    always_comb begin
        dout = sat_val;
        if ((RELU_EN != 0) && sat_val[DATA_W-1]) begin
            dout = '0;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential multiply-accumulate neuron: one weight*activation product per
// clock, then bias add, fixed-point rescale, saturation and optional ReLU.
//   clk     in  1      : clock, rising edge
//   rst_n   in  1      : asynchronous active-low reset
//   start   in  1      : request one evaluation (accepted only in IDLE)
//   bias    in  DATA_W : bias, captured when start is accepted
//   w_addr  out ADDR_W : weight BRAM address
//   w_en    out 1      : weight BRAM enable
//   w_we    out 1      : weight BRAM write enable (always 0)
//   w_do    in  DATA_W : weight BRAM data, valid one rising edge after address
//   x_addr  out ADDR_W : activation BRAM address (mirrors w_addr)
//   x_en    out 1      : activation BRAM enable (mirrors w_en)
//   x_do    in  DATA_W : activation BRAM data, same timing as w_do
//   busy    out 1      : evaluation in progress
//   done    out 1      : one-cycle pulse, result updated
//   result  out DATA_W : neuron output, held until the next done
module neuron_mac_seq
    import nn_pkg::*;
#(
    parameter int N_TAPS  = N_TAPS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int RELU_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_en,
    output logic              w_we,
    input  logic [DATA_W-1:0] w_do,
    output logic [ADDR_W-1:0] x_addr,
    output logic              x_en,
    input  logic [DATA_W-1:0] x_do,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W  = acc_width(DATA_W, N_TAPS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;

    nn_state_t                 state_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic        [DATA_W-1:0]  bias_reg;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [SUM_W-1:0]   acc_ext;
    logic signed [SUM_W-1:0]   bias_ext;
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   scaled;
    logic        [DATA_W-1:0]  sat_out;

    assign w_we   = 1'b0;
    assign x_addr = w_addr;
    assign x_en   = w_en;

    assign prod     = $signed(w_do) * $signed(x_do);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Bias is moved onto the product scale (2*FRAC fractional bits) before
    // the add, so the single rescale below handles both terms.
    assign acc_ext  = {acc_reg[ACC_W-1], acc_reg};
    assign bias_ext = $signed({{(SUM_W-DATA_W){bias_reg[DATA_W-1]}}, bias_reg}) <<< FRAC;
    assign sum      = acc_ext + bias_ext;
    // Arithmetic shift floors toward negative infinity.
    assign scaled   = sum >>> FRAC;

    sat_relu #(
        .IN_W    (SUM_W),
        .DATA_W  (DATA_W),
        .RELU_EN (RELU_EN)
    ) u_sat_relu (
        .din  (scaled),
        .dout (sat_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            w_addr    <= '0;
            w_en      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            acc_reg   <= '0;
            bias_reg  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_addr   <= '0;
                        w_en     <= 1'b1;
                        busy     <= 1'b1;
                        acc_reg  <= '0;
                        bias_reg <= bias;
                        // A single-tap neuron has no intermediate fetches.
                        if (N_TAPS == 1) begin
                            state_reg <= FINAL;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // Data arriving now belongs to the address issued last cycle.
                    acc_reg <= acc_reg + prod_ext;
                    w_addr  <= w_addr + ADDR_W'(1);
                    if (w_addr == ADDR_W'(N_TAPS - 2)) begin
                        state_reg <= FINAL;
                    end
                end
                FINAL: begin
                    acc_reg   <= acc_reg + prod_ext;
                    w_en      <= 1'b0;
                    state_reg <= DONE;
                end
                DONE: begin
                    result    <= sat_out;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;
    localparam int N = 28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bias = '0;

    logic [4:0]  w_addr_a, x_addr_a, w_addr_b, x_addr_b;
    logic        w_en_a, w_we_a, x_en_a, busy_a, done_a;
    logic        w_en_b, w_we_b, x_en_b, busy_b, done_b;
    logic [15:0] w_do_a = '0, x_do_a = '0, w_do_b = '0, x_do_b = '0;
    logic [15:0] result_a, result_b;

    logic [15:0] wmem [N];
    logic [15:0] xmem [N];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] w;
        logic [15:0] x;
        logic [15:0] b;
        logic [15:0] exp_r;
        logic [15:0] exp_n;
    } vec_t;
    vec_t tbl [6];

    neuron_mac_seq #(.RELU_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .w_addr(w_addr_a), .w_en(w_en_a), .w_we(w_we_a), .w_do(w_do_a),
        .x_addr(x_addr_a), .x_en(x_en_a), .x_do(x_do_a),
        .busy(busy_a), .done(done_a), .result(result_a)
    );

    neuron_mac_seq #(.RELU_EN(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .w_addr(w_addr_b), .w_en(w_en_b), .w_we(w_we_b), .w_do(w_do_b),
        .x_addr(x_addr_b), .x_en(x_en_b), .x_do(x_do_b),
        .busy(busy_b), .done(done_b), .result(result_b)
    );

    always #5 clk = ~clk;

    // BRAM models: registered on the falling edge.
    always @(negedge clk) begin
        if (w_en_a) w_do_a <= wmem[int'(w_addr_a)];
        if (x_en_a) x_do_a <= xmem[int'(x_addr_a)];
        if (w_en_b) w_do_b <= wmem[int'(w_addr_b)];
        if (x_en_b) x_do_b <= xmem[int'(x_addr_b)];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < N; i++) begin
            wmem[i] = w;
            xmem[i] = x;
        end
    endtask

    // Reference: exact dot product + bias, floor division by 2^8,
    // clamp to the signed 16-bit range, optional ReLU.
    function automatic logic [15:0] model(input logic [15:0] b, input bit relu);
        longint s;
        longint q;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(wmem[i])) * longint'($signed(xmem[i]));
        end
        s += longint'($signed(b)) * 256;
        if (s >= 0) q = s / 256;
        else        q = -((-s + 255) / 256);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        return 16'(q);
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after the accept edge; returns edges until done (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (done_a || cyc >= 100) break;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] b,
                          input logic [15:0] exp_r, input logic [15:0] exp_n);
        int cyc;
        bias = b;
        pulse_start();
        wait_done(cyc);
        chk({name, " latency"}, cyc, N + 1);
        chk({name, " done_nr"}, int'(done_b), 1);
        chk({name, " result_relu"}, int'(result_a), int'(exp_r));
        chk({name, " result_norelu"}, int'(result_b), int'(exp_n));
        $display("op %s: bias=%h cycles=%0d result=%h/%h expect=%h/%h",
                 name, b, cyc, result_a, result_b, exp_r, exp_n);
        @(posedge clk); #1;
        chk({name, " done_pulse_width"}, int'(done_a), 0);
    endtask

    initial begin
        int cyc;
        int dones;
        int done_at;
        bit seq_ok;
        int q_addr[$];
        int done_cycles[$];
        logic [15:0] er, en, rb;

        tbl[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00};
        tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
        tbl[2] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
        tbl[3] = '{16'hFF00, 16'h0100, 16'h0200, 16'h0000, 16'hE600};
        tbl[4] = '{16'h0080, 16'h0080, 16'hFF80, 16'h0680, 16'h0680};
        tbl[5] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF};

        fill(16'h0000, 16'h0000);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst w_addr", int'(w_addr_a), 0);
        chk("rst w_en",   int'(w_en_a), 0);
        chk("rst w_we",   int'(w_we_a), 0);
        chk("rst busy",   int'(busy_a), 0);
        chk("rst done",   int'(done_a), 0);
        chk("rst result", int'(result_a), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed table
        for (int t = 0; t < 6; t++) begin
            fill(tbl[t].w, tbl[t].x);
            run_op($sformatf("vec%0d", t), tbl[t].b, tbl[t].exp_r, tbl[t].exp_n);
        end

        // Randomized against the reference model
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) begin
                    wmem[i] = 16'($urandom);
                    xmem[i] = 16'($urandom);
                end else begin
                    wmem[i] = 16'(int'($urandom_range(0, 1023)) - 512);
                    xmem[i] = 16'(int'($urandom_range(0, 1023)) - 512);
                end
            end
            rb = (r % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 4095)) - 2048);
            er = model(rb, 1'b1);
            en = model(rb, 1'b0);
            run_op($sformatf("rand%0d", r), rb, er, en);
        end

        // Second START at cycle 10 is ignored; address walk 0..27
        fill(16'h0100, 16'h0100);
        bias = 16'h0000;
        pulse_start();
        q_addr.delete();
        if (w_en_a) q_addr.push_back(int'(w_addr_a));
        dones = 0;
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (w_en_a) q_addr.push_back(int'(w_addr_a));
            if (done_a) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            if (c == 9)  start = 1'b1;
            if (c == 10) start = 1'b0;
        end
        seq_ok = (q_addr.size() == N);
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] != i) seq_ok = 1'b0;
        end
        chk("restart done_count", dones, 1);
        chk("restart done_cycle", done_at, N + 1);
        chk("restart addr_seq", int'(seq_ok), 1);
        chk("restart result", int'(result_a), 16'h1C00);
        $display("op restart: dones=%0d at=%0d addrs=%0d result=%h",
                 dones, done_at, q_addr.size(), result_a);

        // Reset mid-operation, then a clean run
        fill(16'hFF00, 16'h0100);
        bias = 16'h0200;
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst w_en",   int'(w_en_a), 0);
        chk("midrst busy",   int'(busy_a), 0);
        chk("midrst result", int'(result_a), 0);
        chk("midrst done",   int'(done_a), 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("midrst hold_done", int'(done_a), 0);
            chk("midrst hold_busy", int'(busy_a), 0);
        end
        rst_n = 1'b1;
        $display("op midreset: asserted for 2 cycles at cycle 12");
        fill(16'h0100, 16'h0100);
        run_op("post_reset", 16'h0000, 16'h1C00, 16'h1C00);

        // START held high: one operation every 30 cycles
        for (int i = 0; i < N; i++) begin
            wmem[i] = 16'(int'($urandom_range(0, 511)) - 256);
            xmem[i] = 16'(int'($urandom_range(0, 511)) - 256);
        end
        rb = 16'h0100;
        bias = rb;
        er = model(rb, 1'b1);
        en = model(rb, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        done_cycles.delete();
        for (int c = 1; c <= 92; c++) begin
            @(posedge clk); #1;
            if (done_a) begin
                done_cycles.push_back(c);
                chk("held result_relu", int'(result_a), int'(er));
                chk("held result_norelu", int'(result_b), int'(en));
                $display("op held: done at cycle %0d result=%h/%h", c, result_a, result_b);
            end
        end
        start = 1'b0;
        chk("held done_count", done_cycles.size(), 3);
        if (done_cycles.size() == 3) begin
            chk("held done1", done_cycles[0], 29);
            chk("held done2", done_cycles[1], 59);
            chk("held done3", done_cycles[2], 89);
        end
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 Parameter N_TAPS, default 28: weights per neuron, equal to the depth of the weight BRAM.
REQ-002 Parameter ADDR_W, default 5: BRAM address width; 2^ADDR_W SHALL be >= N_TAPS.
REQ-003 Parameter DATA_W, default 16: width of weight, activation, bias and result words, all signed two's complement.
REQ-004 Parameter FRAC, default 8: fractional bits of the fixed-point format (Q8.8 at defaults).
REQ-005 Parameter RELU_EN, default 1: 1 applies ReLU to the result, 0 passes it through.
REQ-006 CLK  in  1: single clock; all state SHALL update on its rising edge.
REQ-007 RST_N  in  1: asynchronous, active-low reset.
REQ-008 START  in  1: single-cycle request to evaluate one neuron.
REQ-009 BIAS  in  DATA_W: neuron bias, sampled on the START-accept edge.
REQ-010 W_ADDR  out  ADDR_W: address to the weight BRAM.
REQ-011 W_EN  out  1: weight BRAM enable.
REQ-012 W_WE  out  1: weight BRAM write enable; SHALL be tied to 0.
REQ-013 W_DO  in  DATA_W: weight BRAM read data, valid at the rising edge after the address is driven (the BRAM registers on the falling edge).
REQ-014 X_ADDR  out  ADDR_W: address to the activation BRAM; SHALL always equal W_ADDR.
REQ-015 X_EN  out  1: activation BRAM enable; SHALL always equal W_EN.
REQ-016 X_DO  in  DATA_W: activation BRAM read data, with the same timing as W_DO.
REQ-017 BUSY  out  1: high from the START-accept edge until DONE is asserted.
REQ-018 DONE  out  1: one-cycle pulse indicating RESULT is new.
REQ-019 RESULT  out  DATA_W: neuron output, held until the next DONE.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, FINAL and DONE; all outputs SHALL be registered.
REQ-021 IDLE, START=1 -> FETCH: on that edge (cycle 0) W_ADDR=0, W_EN=1, BUSY=1, accumulator cleared, BIAS captured.
- If START is low, the block SHALL remain in IDLE with W_EN=0.
REQ-022 FETCH, edge k (k=1..N_TAPS-1): the accumulator SHALL add W_DO*X_DO, and W_ADDR SHALL become k.
- On edge N_TAPS-1 the state SHALL go to FINAL.
REQ-023 FINAL, edge N_TAPS: the accumulator SHALL add the last product, W_EN SHALL go to 0, and the state SHALL go to DONE.
REQ-024 DONE, edge N_TAPS+1: the block SHALL load RESULT, pulse DONE=1 for one cycle, set BUSY=0 and return to IDLE.
- START-to-DONE latency SHALL be N_TAPS+1 cycles (29 at defaults).
REQ-025 Each product SHALL be a full 2*DATA_W signed value.
- The accumulator SHALL be 2*DATA_W+ceil(log2(N_TAPS)) bits (37 at defaults) and SHALL never wrap.
REQ-026 Result computation:
- sum = acc + (BIAS <<< FRAC);
- scaled = sum >>> FRAC, an arithmetic shift that truncates toward negative infinity;
- scaled SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
- if RELU_EN=1, negative values SHALL become 0.
REQ-027 START while BUSY=1 SHALL be ignored, with no queueing.
- START during the DONE cycle SHALL be ignored.
- START is accepted from the following IDLE cycle onward.
REQ-028 W_ADDR SHALL never exceed N_TAPS-1, and SHALL hold its last value while W_EN=0.

Reset
REQ-029 When RST_N=0 at any time, including mid-operation, the block SHALL immediately force:
- state = IDLE;
- W_ADDR = 0, W_EN = 0;
- BUSY = 0, DONE = 0;
- RESULT = 0;
- accumulator = 0.
REQ-030 After RST_N deasserts, the first START SHALL produce a correct result with no residue from the aborted operation.

Structure
REQ-031 The FSM state encoding and the default constants (N_TAPS, ADDR_W, DATA_W, FRAC) SHALL live in the shared package nn_pkg.
REQ-032 The saturate-and-ReLU stage SHALL be the single sub-module sat_relu, which is combinational and parameterised by its input width, DATA_W and RELU_EN.
REQ-033 The weight and activation BRAMs SHALL be instantiated outside this block.

Verification
REQ-034 All weights 0x0100, all activations 0x0100, BIAS=0 -> DONE 29 cycles after START, RESULT=0x1C00 (28.0).
REQ-035 All weights 0x7FFF, all activations 0x7FFF -> RESULT=0x7FFF (saturated).
- Same data with RELU_EN=0 and all weights 0x8000 -> RESULT=0x8000.
REQ-036 Weights 0xFF00 (-1.0), activations 0x0100, BIAS=0x0200 -> RESULT=0x0000 with RELU_EN=1, 0xE600 (-26.0) with RELU_EN=0.
REQ-037 Second START pulsed at cycle 10 of an operation -> ignored.
- Exactly one DONE pulse follows, at cycle 29.
- W_ADDR sequence is 0..27 with no repeats.
REQ-038 RST_N low for 2 cycles at cycle 12:
- during reset: W_EN=0, BUSY=0, RESULT=0, no DONE pulse;
- then a START with the REQ-034 data -> RESULT=0x1C00.
REQ-039 START held high continuously -> one operation per 30 cycles, each producing a correct RESULT.
